// File: rtl/soc_pkg.sv
// Definitions shared across the SoC fetch path: loader state encoding and the
// default filler instruction returned for reads with no program word behind them.
package soc_pkg;

    typedef enum logic {
        LDR_LOAD = 1'b0,
        LDR_RUN  = 1'b1
    } ldr_state_e;

    localparam logic [31:0] SOC_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port and one registered read port.
// The read register only updates when re_i is high, so it holds its last value otherwise.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately never reset; the loader's length register gates reachability.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a LOAD phase (streamed program words appended in order)
// and a RUN phase (one-cycle-latency fetch, bounds-checked against the loaded length).
module instr_mem_loader
    import soc_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(SOC_NOP_WORD),
    localparam int               ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk_input,
    input  logic              rst,
    input  logic              prg_mode,
    input  logic [31:0]       address_pointer,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              wr_addr_clr,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              addr_err,
    output logic [ADDR_W:0]   prog_len,
    output logic              load_full,
    output logic              load_ovf,
    output ldr_state_e        dbg_state
);

    localparam int              CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    ldr_state_e       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             rd_valid_q, rd_valid_d;
    logic             addr_err_q, addr_err_d;
    logic             use_ram_q, use_ram_d;

    logic              is_load;
    logic              full;
    logic              wr_fire;
    logic              addr_hit;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    // Write handshake: a word transfers on any edge where wr_valid && wr_ready.
    // wr_ready depends only on state, fullness and wr_addr_clr, never on wr_valid.
    assign is_load  = (state_q == LDR_LOAD);
    assign full     = (len_q == DEPTH_C);
    assign wr_ready = is_load & ~full & ~wr_addr_clr;
    assign wr_fire  = wr_valid & wr_ready;

    // Full-width compare: high address bits must never alias into the array.
    assign addr_hit = (33'(address_pointer) < 33'(len_q));

    always_comb begin
        state_d    = prg_mode ? LDR_RUN : LDR_LOAD;
        len_d      = len_q;
        ovf_d      = ovf_q;
        rd_valid_d = rd_valid_q;
        addr_err_d = addr_err_q;
        use_ram_d  = use_ram_q;
        if (is_load) begin
            rd_valid_d = 1'b0;
            addr_err_d = 1'b0;
            if (wr_addr_clr) begin
                len_d = '0;
                ovf_d = 1'b0;
            end else if (wr_valid) begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    len_d = len_q + CNT_W'(1);
                end
            end
        end else begin
            rd_valid_d = 1'b1;
            addr_err_d = ~addr_hit;
            use_ram_d  = addr_hit;
        end
    end

    always_ff @(posedge clk_input) begin
        if (rst) begin
            state_q    <= LDR_LOAD;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            use_ram_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
            use_ram_q  <= use_ram_d;
        end
    end

    // The write pointer is the length register itself, so the two can never diverge.
    assign ram_we = wr_fire & ~rst;
    assign ram_re = ~is_load & addr_hit & ~rst;

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk_input),
        .we_i    (ram_we),
        .waddr_i (len_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .re_i    (ram_re),
        .raddr_i (address_pointer[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    // use_ram_q holds through LOAD, so rdata keeps the last fetch result there.
    assign rdata     = use_ram_q ? ram_rdata : NOP_WORD;
    assign rd_valid  = rd_valid_q;
    assign addr_err  = addr_err_q;
    assign prog_len  = len_q;
    assign load_full = full;
    assign load_ovf  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed vector table followed by random traffic,
// both checked against an array-based model of the program memory.
module tb_instr_mem_loader;
  import soc_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'hDEAD_BEEF;

  logic        clk_input;
  logic        rst;
  logic        prg_mode;
  logic [31:0] address_pointer;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        wr_addr_clr;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        addr_err;
  logic [2:0]  prog_len;
  logic        load_full;
  logic        load_ovf;
  ldr_state_e  dbg_state;

  instr_mem_loader #(
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk_input       (clk_input),
    .rst             (rst),
    .prg_mode        (prg_mode),
    .address_pointer (address_pointer),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .wr_addr_clr     (wr_addr_clr),
    .rdata           (rdata),
    .rd_valid        (rd_valid),
    .addr_err        (addr_err),
    .prog_len        (prog_len),
    .load_full       (load_full),
    .load_ovf        (load_ovf),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial begin
    clk_input = 1'b0;
    forever #5 clk_input = ~clk_input;
  end

  // reference model: program memory as a plain array plus a word count
  logic [31:0] m_mem [DEPTH];
  int          m_len;
  bit          m_running;
  bit          m_ovf;
  bit          m_rdv;
  bit          m_err;
  logic [31:0] m_rdata;
  bit          m_known;

  // scoreboard
  logic [31:0] exp_q[$];
  int total;
  int bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: present one cycle of inputs, advance the model, compare after the edge
  task automatic apply(input bit r, input bit pm, input bit clr, input bit v,
                       input logic [31:0] d, input logic [31:0] ap);
    longint unsigned a;
    @(negedge clk_input);
    rst = r; prg_mode = pm; wr_addr_clr = clr; wr_valid = v;
    wr_data = d; address_pointer = ap;
    #1;
    if (m_known)
      check("wr_ready", 32'(wr_ready), 32'(!m_running && m_len != DEPTH && !clr));
    a = ap;
    if (r) begin
      m_running = 0; m_len = 0; m_ovf = 0; m_rdv = 0; m_err = 0; m_rdata = NOP;
      m_known = 1;
    end else begin
      if (!m_running) begin
        m_rdv = 0;
        m_err = 0;
        if (clr) begin
          m_len = 0;
          m_ovf = 0;
        end else if (v) begin
          if (m_len == DEPTH) m_ovf = 1;
          else begin
            m_mem[m_len] = d;
            m_len++;
          end
        end
      end else begin
        m_rdv = 1;
        m_err = (a >= longint'(m_len));
        m_rdata = m_err ? NOP : m_mem[a];
      end
      m_running = pm;
    end
    exp_q.push_back(m_rdata);
    @(posedge clk_input);
    #1;
    check("rdata", rdata, exp_q.pop_front());
    check("prog_len", 32'(prog_len), 32'(m_len));
    check("load_full", 32'(load_full), 32'(m_len == DEPTH));
    check("load_ovf", 32'(load_ovf), 32'(m_ovf));
    check("rd_valid", 32'(rd_valid), 32'(m_rdv));
    check("addr_err", 32'(addr_err), 32'(m_err));
  endtask

  typedef struct {
    bit          r, pm, clr, v;
    logic [31:0] d, ap;
    int          e_len;
    bit          e_ovf, e_rdv, e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit pm, input bit clr, input bit v,
                     input logic [31:0] d, input logic [31:0] ap, input int e_len,
                     input bit e_ovf, input bit e_rdv, input bit e_err, input logic [31:0] e_rd);
    vec_t t;
    t.r = r; t.pm = pm; t.clr = clr; t.v = v; t.d = d; t.ap = ap;
    t.e_len = e_len; t.e_ovf = e_ovf; t.e_rdv = e_rdv; t.e_err = e_err; t.e_rd = e_rd;
    vecs.push_back(t);
  endtask

  initial begin
    total = 0; bad = 0; m_known = 0;
    rst = 1'b0; prg_mode = 1'b0; wr_addr_clr = 1'b0; wr_valid = 1'b0;
    wr_data = '0; address_pointer = '0;

    //   r pm clr v  data          addr          len ovf rdv err rdata
    add(1, 0, 0, 0, 32'h0,        32'h0,        0,  0,  0,  0,  NOP);
    add(0, 0, 0, 1, 32'h11,       32'h0,        1,  0,  0,  0,  NOP);
    add(0, 0, 0, 1, 32'h22,       32'h0,        2,  0,  0,  0,  NOP);
    add(0, 0, 0, 1, 32'h33,       32'h0,        3,  0,  0,  0,  NOP);
    add(0, 0, 0, 1, 32'h44,       32'h0,        4,  0,  0,  0,  NOP);
    add(0, 0, 0, 1, 32'h55,       32'h0,        4,  1,  0,  0,  NOP);  // offered while full
    add(0, 1, 0, 0, 32'h0,        32'h2,        4,  1,  0,  0,  NOP);  // first RUN cycle is still LOAD
    add(0, 1, 0, 0, 32'h0,        32'h2,        4,  1,  1,  0,  32'h33);
    add(0, 1, 0, 0, 32'h0,        32'h4,        4,  1,  1,  1,  NOP);
    add(0, 1, 0, 0, 32'h0,        32'hFFFF_FFFF,4,  1,  1,  1,  NOP);
    add(0, 1, 0, 0, 32'h0,        32'h3,        4,  1,  1,  0,  32'h44); // mem[3] kept
    add(0, 1, 1, 1, 32'h99,       32'h0,        4,  1,  1,  0,  32'h11); // writes ignored in RUN
    add(0, 0, 0, 0, 32'h0,        32'h0,        4,  1,  1,  0,  32'h11);
    add(0, 0, 1, 1, 32'h66,       32'h0,        0,  0,  0,  0,  32'h11); // clr drops the word
    add(0, 0, 0, 1, 32'h77,       32'h0,        1,  0,  0,  0,  32'h11);
    add(0, 1, 0, 0, 32'h0,        32'h0,        1,  0,  0,  0,  32'h11);
    add(0, 1, 0, 0, 32'h0,        32'h0,        1,  0,  1,  0,  32'h77);
    add(0, 1, 0, 0, 32'h0,        32'h1,        1,  0,  1,  1,  NOP);
    add(0, 0, 0, 0, 32'h0,        32'h0,        1,  0,  1,  0,  32'h77);
    add(0, 0, 1, 0, 32'h0,        32'h0,        0,  0,  0,  0,  32'h77);
    add(0, 0, 0, 1, 32'hA1,       32'h0,        1,  0,  0,  0,  32'h77);
    add(0, 0, 0, 1, 32'hA2,       32'h0,        2,  0,  0,  0,  32'h77);
    add(0, 1, 0, 0, 32'h0,        32'h1,        2,  0,  0,  0,  32'h77);
    add(0, 1, 0, 0, 32'h0,        32'h1,        2,  0,  1,  0,  32'hA2);
    add(0, 0, 0, 0, 32'h0,        32'h1,        2,  0,  1,  0,  32'hA2);
    add(0, 0, 0, 1, 32'hA3,       32'h0,        3,  0,  0,  0,  32'hA2); // append after RUN
    add(0, 1, 0, 0, 32'h0,        32'h2,        3,  0,  0,  0,  32'hA2);
    add(0, 1, 0, 0, 32'h0,        32'h2,        3,  0,  1,  0,  32'hA3);
    add(1, 1, 0, 0, 32'h0,        32'h2,        0,  0,  0,  0,  NOP);    // reset mid-RUN
    add(0, 1, 0, 0, 32'h0,        32'h0,        0,  0,  0,  0,  NOP);
    add(0, 1, 0, 0, 32'h0,        32'h0,        0,  0,  1,  1,  NOP);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].pm, vecs[i].clr, vecs[i].v, vecs[i].d, vecs[i].ap);
      check($sformatf("vec%0d.prog_len", i), 32'(prog_len), 32'(vecs[i].e_len));
      check($sformatf("vec%0d.load_ovf", i), 32'(load_ovf), 32'(vecs[i].e_ovf));
      check($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rdv));
      check($sformatf("vec%0d.addr_err", i), 32'(addr_err), 32'(vecs[i].e_err));
      check($sformatf("vec%0d.rdata", i), rdata, vecs[i].e_rd);
    end

    // random traffic against the model
    begin
      bit pm_r;
      pm_r = 0;
      for (int n = 0; n < 800; n++) begin
        bit          r_r, clr_r, v_r;
        logic [31:0] ap_r;
        if ($urandom_range(0, 7) == 0) pm_r = ~pm_r;
        r_r   = ($urandom_range(0, 63) == 0);
        clr_r = ($urandom_range(0, 11) == 0);
        v_r   = $urandom_range(0, 1);
        ap_r  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 5));
        apply(r_r, pm_r, clr_r, v_r, 32'($urandom), ap_r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction word width.
REQ-002 SHALL have parameter DEPTH, default 256: number of words, any value >= 2.
REQ-003 SHALL have parameter NOP_WORD, default 0: word returned for out-of-range reads and after reset.
REQ-004 SHALL have local constant ADDR_W = clog2(DEPTH), with count width ADDR_W+1.
REQ-005 SHALL have port clk_input, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port prg_mode, input, 1 bit: 0 = LOAD (program), 1 = RUN (fetch).
REQ-008 SHALL have port address_pointer, input, 32 bits: fetch address in RUN.
REQ-009 SHALL have port wr_valid, input, 1 bit: load word offered.
REQ-010 SHALL have port wr_data, input, DATA_W bits: load word.
REQ-011 SHALL have port wr_ready, output, 1 bit: load word accepted this cycle if wr_valid.
REQ-012 SHALL have port wr_addr_clr, input, 1 bit: restart load at address 0.
REQ-013 SHALL have port rdata, output, DATA_W bits: fetched instruction.
REQ-014 SHALL have port rd_valid, output, 1 bit: rdata holds a RUN-mode fetch result.
REQ-015 SHALL have port addr_err, output, 1 bit: the last fetch address was >= prog_len.
REQ-016 SHALL have port prog_len, output, ADDR_W+1 bits: words loaded.
REQ-017 SHALL have port load_full, output, 1 bit: prog_len == DEPTH.
REQ-018 SHALL have port load_ovf, output, 1 bit: sticky flag set when a word is offered while full.

Function
REQ-019 SHALL hold a two-state FSM {LOAD, RUN}; state <= RUN when prg_mode=1, else LOAD, registered each cycle.
REQ-020 SHALL drive wr_ready = (state==LOAD) & ~load_full & ~wr_addr_clr, combinationally.
REQ-021 SHALL, on wr_valid & wr_ready, write mem[wptr] <= wr_data and increment both wptr and prog_len by 1; wptr and prog_len are equal at all times.
REQ-022 SHALL, on wr_addr_clr in LOAD, set wptr = prog_len = 0; a simultaneous wr_valid is dropped and not written.
REQ-023 SHALL, on wr_valid in LOAD while load_full, discard the word and set load_ovf; load_ovf clears only on rst or wr_addr_clr.
REQ-024 SHALL, on re-entry into LOAD without wr_addr_clr, append at the current wptr.
REQ-025 SHALL, in RUN each cycle, register rdata <= mem[address_pointer] if address_pointer < prog_len, else NOP_WORD; rd_valid <= 1; addr_err <= (address_pointer >= prog_len); latency is 1 cycle.
REQ-026 SHALL compare the full 32-bit address_pointer, with no truncation or wrap.
REQ-027 SHALL, in LOAD, set rd_valid <= 0 and addr_err <= 0, hold rdata, and ignore wr_valid/wr_addr_clr in RUN.
REQ-028 SHALL, on the first cycle prg_mode rises, still treat that cycle as LOAD; the first fetch is sampled on the following edge.

Reset
REQ-029 SHALL, on rst, set state=LOAD, wptr=prog_len=0, rdata=NOP_WORD, rd_valid=0, addr_err=0, load_ovf=0; rst overrides every other input on that edge.
REQ-030 SHALL NOT reset memory contents; they are unreachable until rewritten because prog_len=0.

Structure
REQ-031 SHALL take the state encoding and the default NOP_WORD from the shared package soc_pkg.
REQ-032 SHALL place the storage array in a single sub-module imem_ram (1 write port, 1 registered read port), with the FSM, pointers and flags in instr_mem_loader.

Verification
REQ-033 SHALL cover: reset, LOAD, 4 words 0x11,0x22,0x33,0x44 -> prog_len=4; RUN, addr 2 -> next cycle rdata=0x33, rd_valid=1, addr_err=0.
REQ-034 SHALL cover: RUN, addr 4 and addr 0xFFFF_FFFF -> rdata=NOP_WORD, addr_err=1.
REQ-035 SHALL cover: DEPTH=4, offer 5 words -> load_full=1 after 4 words, wr_ready=0, load_ovf=1, and mem[3] unchanged by the 5th word.
REQ-036 SHALL cover: wr_addr_clr asserted together with wr_valid -> prog_len=0, no write; the next word lands at address 0.
REQ-037 SHALL cover: LOAD 2 words, RUN, LOAD 1 word -> prog_len=3, the new word at address 2.
REQ-038 SHALL cover: rst asserted mid-RUN -> next cycle rd_valid=0, rdata=NOP_WORD, prog_len=0, and a fetch at address 0 gives addr_err=1.
